// File: rtl/seven_seg_pkg.sv
// Shared glyph constants and slot-phase type for the multiplexed seven-segment scanner.
package seven_seg_pkg;

  // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    ON    = 2'd1,
    OFF   = 2'd2
  } slot_phase_e;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seven_seg_decode (
  input  logic [3:0] nibble,
  output logic [6:0] seg_code
);
  import seven_seg_pkg::*;

  // Glyph lookup
  always_comb begin
    case (nibble)
      4'h0:    seg_code = SEG_0;
      4'h1:    seg_code = SEG_1;
      4'h2:    seg_code = SEG_2;
      4'h3:    seg_code = SEG_3;
      4'h4:    seg_code = SEG_4;
      4'h5:    seg_code = SEG_5;
      4'h6:    seg_code = SEG_6;
      4'h7:    seg_code = SEG_7;
      4'h8:    seg_code = SEG_8;
      4'h9:    seg_code = SEG_9;
      4'hA:    seg_code = SEG_A;
      4'hB:    seg_code = SEG_B;
      4'hC:    seg_code = SEG_C;
      4'hD:    seg_code = SEG_D;
      4'hE:    seg_code = SEG_E;
      4'hF:    seg_code = SEG_F;
      default: seg_code = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed N-digit common-anode hex display driver with double-buffered loading,
// anti-ghost blanking, 16-level brightness PWM and leading-zero suppression.
module seven_seg_scan #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_COUNT = 32768,
  parameter int BLANK_CYCLES  = 256,
  parameter int LZ_SUPPRESS   = 1
) (
  input  logic                    clk_10MHz,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [3:0]              brightness,
  input  logic                    blank_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  import seven_seg_pkg::*;

  localparam int DW      = 4 * NUM_DIGITS;
  localparam int ON_UNIT = (REFRESH_COUNT - BLANK_CYCLES) / 16;
  localparam int CNT_W   = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  // One extra bit: the end of the ON window can equal REFRESH_COUNT itself.
  localparam logic [CNT_W:0]   BLANK_END = (CNT_W+1)'(BLANK_CYCLES);
  localparam logic [CNT_W:0]   ON_STEP   = (CNT_W+1)'(ON_UNIT);

  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_next_s;
  logic [IDX_W-1:0]      idx_r;
  logic [IDX_W-1:0]      idx_next_s;
  logic                  cnt_wrap_s;
  logic                  boundary_s;
  logic                  fd_next_s;

  logic [DW-1:0]         pend_digits_r;
  logic [NUM_DIGITS-1:0] pend_dp_r;
  logic                  pend_flag_r;
  logic [DW-1:0]         shd_digits_r;
  logic [NUM_DIGITS-1:0] shd_dp_r;

  logic [CNT_W:0]        on_end_s;
  slot_phase_e           phase_s;
  logic                  an_on_s;
  logic [3:0]            nib_s;
  logic                  dp_sel_s;
  logic                  upper_nz_s;
  logic                  suppress_s;
  logic [6:0]            glyph_s;
  logic [6:0]            seg_next_s;
  logic [NUM_DIGITS-1:0] an_next_s;

  logic [6:0]            seg_r;
  logic                  dp_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic                  fd_r;

  assign seg        = seg_r;
  assign dp         = dp_r;
  assign an         = an_r;
  assign frame_done = fd_r;

  // Slot counter / digit index successor and frame boundary detection
  always_comb begin
    cnt_wrap_s = (cnt_r == CNT_MAX);
    boundary_s = cnt_wrap_s && (idx_r == IDX_MAX);
    if (cnt_wrap_s) begin
      cnt_next_s = '0;
      if (idx_r == IDX_MAX) begin
        idx_next_s = '0;
      end else begin
        idx_next_s = idx_r + IDX_W'(1'b1);
      end
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1'b1);
      idx_next_s = idx_r;
    end
    // frame_done is registered but must coincide with the boundary state itself.
    fd_next_s = (cnt_next_s == CNT_MAX) && (idx_next_s == IDX_MAX);
  end

  // Slot counter, digit index and frame_done pulse
  always_ff @(posedge clk_10MHz) begin
    if (!reset_n) begin
      cnt_r <= '0;
      idx_r <= '0;
      fd_r  <= 1'b0;
    end else begin
      cnt_r <= cnt_next_s;
      idx_r <= idx_next_s;
      fd_r  <= fd_next_s;
    end
  end

  // Pending/shadow double buffer; the shadow only moves on a frame boundary
  always_ff @(posedge clk_10MHz) begin
    if (!reset_n) begin
      pend_digits_r <= '0;
      pend_dp_r     <= '0;
      pend_flag_r   <= 1'b0;
      shd_digits_r  <= '0;
      shd_dp_r      <= '0;
    end else if (boundary_s) begin
      if (load) begin
        shd_digits_r <= digits;
        shd_dp_r     <= dp_in;
      end else if (pend_flag_r) begin
        shd_digits_r <= pend_digits_r;
        shd_dp_r     <= pend_dp_r;
      end else begin
        shd_digits_r <= shd_digits_r;
        shd_dp_r     <= shd_dp_r;
      end
      pend_flag_r <= 1'b0;
    end else if (load) begin
      pend_digits_r <= digits;
      pend_dp_r     <= dp_in;
      pend_flag_r   <= 1'b1;
    end else begin
      pend_flag_r <= pend_flag_r;
    end
  end

  // Select the active digit's nibble/dp and detect nonzero digits at or above it
  always_comb begin
    nib_s      = 4'h0;
    dp_sel_s   = 1'b0;
    upper_nz_s = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib_s      = nib_s | (shd_digits_r[4*i +: 4] & {4{idx_r == IDX_W'(i)}});
      dp_sel_s   = dp_sel_s | (shd_dp_r[i] & (idx_r == IDX_W'(i)));
      upper_nz_s = upper_nz_s | ((IDX_W'(i) >= idx_r) && (|shd_digits_r[4*i +: 4]));
    end
    suppress_s = (LZ_SUPPRESS != 0) && (idx_r != '0) && !upper_nz_s;
  end

  seven_seg_decode u_decode (
    .nibble   (nib_s),
    .seg_code (glyph_s)
  );

  // Slot phase, anode pattern and segment pattern for the next output register
  always_comb begin
    on_end_s = BLANK_END + ON_STEP * ((CNT_W+1)'(brightness) + (CNT_W+1)'(1'b1));
    if ({1'b0, cnt_r} < BLANK_END) begin
      phase_s = BLANK;
    end else if ({1'b0, cnt_r} < on_end_s) begin
      phase_s = ON;
    end else begin
      phase_s = OFF;
    end
    case (phase_s)
      ON:      an_on_s = !blank_in;
      default: an_on_s = 1'b0;
    endcase
    an_next_s = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_next_s[i] = !(an_on_s && (idx_r == IDX_W'(i)));
    end
    seg_next_s = suppress_s ? SEG_BLANK : glyph_s;
  end

  // Registered pin drivers
  always_ff @(posedge clk_10MHz) begin
    if (!reset_n) begin
      an_r  <= '1;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_next_s;
      seg_r <= seg_next_s;
      dp_r  <= ~dp_sel_s;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: time-based reference model plus directed frame checks.
module tb_seven_seg_scan;

  localparam int ND    = 4;
  localparam int RC    = 64;
  localparam int BC    = 16;
  localparam int ON_U  = 3;
  localparam int FRAME = RC * ND;

  logic        clk_10MHz  = 1'b0;
  logic        reset_n    = 1'b0;
  logic [15:0] digits     = 16'h0000;
  logic [3:0]  dp_in      = 4'b0000;
  logic        load       = 1'b0;
  logic [3:0]  brightness = 4'd15;
  logic        blank_in   = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  seven_seg_scan #(
    .NUM_DIGITS    (ND),
    .REFRESH_COUNT (RC),
    .BLANK_CYCLES  (BC),
    .LZ_SUPPRESS   (1)
  ) dut (
    .clk_10MHz  (clk_10MHz),
    .reset_n    (reset_n),
    .digits     (digits),
    .dp_in      (dp_in),
    .load       (load),
    .brightness (brightness),
    .blank_in   (blank_in),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #50 clk_10MHz = ~clk_10MHz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: absolute time since reset release drives slot position.
  logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          m_t;
  int          mc;
  int          mi;
  bit          m_on;
  bit          m_valid = 1'b0;
  logic [15:0] m_shd, m_pend;
  logic [3:0]  m_shd_dp, m_pend_dp;
  bit          m_flag;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fd;

  initial begin : model
    forever begin
      @(posedge clk_10MHz);
      if (!reset_n) begin
        m_t = 0; m_shd = 16'h0; m_pend = 16'h0; m_shd_dp = 4'h0; m_pend_dp = 4'h0; m_flag = 1'b0;
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
      end else begin
        mc = m_t % RC;
        mi = (m_t / RC) % ND;
        m_on = !blank_in && (mc >= BC) && (mc < BC + ON_U * (brightness + 1));
        exp_an = m_on ? ~(4'b0001 << mi) : 4'hF;
        if (mi > 0 && (m_shd >> (4 * mi)) == 16'h0) exp_seg = 7'h7F;
        else exp_seg = GLYPH[m_shd[4*mi +: 4]];
        exp_dp = ~m_shd_dp[mi];
        if ((m_t % FRAME) == FRAME - 1) begin
          if (load) begin m_shd = digits; m_shd_dp = dp_in; end
          else if (m_flag) begin m_shd = m_pend; m_shd_dp = m_pend_dp; end
          m_flag = 1'b0;
        end else if (load) begin
          m_pend = digits; m_pend_dp = dp_in; m_flag = 1'b1;
        end
        m_t++;
        exp_fd = (m_t % FRAME) == FRAME - 1;
      end
      m_valid = 1'b1;
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk_10MHz);
      if (m_valid) begin
        check("model_an", an, exp_an);
        check("model_seg", seg, exp_seg);
        check("model_dp", dp, exp_dp);
        check("model_frame_done", frame_done, exp_fd);
      end
    end
  end

  task automatic tick();
    @(negedge clk_10MHz);
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin tick(); n++; end while (!frame_done && n < 600);
    check("frame_done_wait", frame_done, 1'b1);
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] d);
    digits = v; dp_in = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  logic [6:0] obs_seg [4];
  logic       obs_dp  [4];
  int         obs_on  [4];
  int         obs_fd;

  // Called on a boundary negedge; samples the 256 cycles of the following frame.
  task automatic observe_frame();
    obs_fd = 0;
    for (int d = 0; d < 4; d++) begin obs_seg[d] = 7'bx; obs_dp[d] = 1'bx; obs_on[d] = 0; end
    for (int j = 0; j < FRAME; j++) begin
      tick();
      load = 1'b0;
      for (int d = 0; d < 4; d++) begin
        if (an[d] == 1'b0) begin obs_on[d]++; obs_seg[d] = seg; obs_dp[d] = dp; end
      end
      if (frame_done) obs_fd++;
    end
  endtask

  task automatic show(input logic [15:0] v);
    repeat (20) tick();
    load_val(v, 4'b0000);
    wait_fd();
    observe_frame();
  endtask

  initial begin : watchdog
    #(100 * 30000);
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int first_low = -1;
    int low_cnt   = 0;
    int first_fd  = -1;
    int n;

    repeat (3) tick();
    check("reset_an", an, 4'hF);
    check("reset_seg", seg, 7'h7F);
    check("reset_dp", dp, 1'b1);
    check("reset_frame_done", frame_done, 1'b0);

    for (int k = 0; k < 300; k++) begin
      if (an != 4'hF && first_low < 0) first_low = k;
      if (k <= 64 && an == 4'b1110) begin
        low_cnt++;
        check("first_slot_seg", seg, 7'h40);
      end
      if (frame_done && first_fd < 0) first_fd = k;
      if (k == 0) reset_n = 1'b1;
      tick();
    end
    check("first_on_cycle", first_low, 17);
    check("first_slot_on_len", low_cnt, 48);
    check("first_frame_done_cycle", first_fd, 255);

    load_val(16'h12AF, 4'b0100);
    wait_fd();
    observe_frame();
    check("glyph_d0_F", obs_seg[0], 7'h0E);
    check("glyph_d1_A", obs_seg[1], 7'h08);
    check("glyph_d2_2", obs_seg[2], 7'h24);
    check("glyph_d3_1", obs_seg[3], 7'h79);
    check("dp_d2_lit", obs_dp[2], 1'b0);
    check("dp_d0_off", obs_dp[0], 1'b1);
    check("on_len_b15_d0", obs_on[0], 48);

    brightness = 4'd0;
    observe_frame();
    check("on_len_b0_d0", obs_on[0], 3);
    check("on_len_b0_d3", obs_on[3], 3);
    brightness = 4'd7;
    observe_frame();
    check("on_len_b7_d1", obs_on[1], 24);
    check("on_len_b7_d3", obs_on[3], 24);
    brightness = 4'd15;
    observe_frame();
    check("on_len_b15_d2", obs_on[2], 48);
    check("on_len_b15_d3", obs_on[3], 48);

    show(16'h0005);
    check("lz0005_d0", obs_seg[0], 7'h12);
    check("lz0005_d1", obs_seg[1], 7'h7F);
    check("lz0005_d3", obs_seg[3], 7'h7F);
    show(16'h0000);
    check("lz0000_d0", obs_seg[0], 7'h40);
    check("lz0000_d2", obs_seg[2], 7'h7F);
    show(16'h0500);
    check("lz0500_d3", obs_seg[3], 7'h7F);
    check("lz0500_d2", obs_seg[2], 7'h12);
    check("lz0500_d1", obs_seg[1], 7'h40);
    check("lz0500_d0", obs_seg[0], 7'h40);

    repeat (50) tick();
    load_val(16'h1111, 4'b0000);
    repeat (50) tick();
    load_val(16'h2222, 4'b0000);
    wait_fd();
    observe_frame();
    check("overwrite_d0", obs_seg[0], 7'h24);
    check("overwrite_d3", obs_seg[3], 7'h24);

    digits = 16'h3333; dp_in = 4'b0000; load = 1'b1;
    observe_frame();
    check("boundary_load_d0", obs_seg[0], 7'h30);
    check("boundary_load_d3", obs_seg[3], 7'h30);

    blank_in = 1'b1;
    observe_frame();
    blank_in = 1'b0;
    check("blank_on_d0", obs_on[0], 0);
    check("blank_on_d3", obs_on[3], 0);
    check("blank_frame_done", obs_fd, 1);

    repeat (10) tick();
    load_val(16'h7777, 4'hF);
    n = 0;
    while (an == 4'hF && n < 300) begin tick(); n++; end
    check("reach_on_phase", an != 4'hF, 1'b1);
    reset_n = 1'b0;
    tick();
    check("midreset_an", an, 4'hF);
    check("midreset_seg", seg, 7'h7F);
    check("midreset_dp", dp, 1'b1);
    reset_n = 1'b1;
    wait_fd();
    observe_frame();
    check("pending_lost_d0", obs_seg[0], 7'h40);
    check("pending_lost_d1", obs_seg[1], 7'h7F);
    check("pending_lost_dp", obs_dp[0], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
